// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_pkg;

  // Source chosen for the next fetch address.
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_SEQ,
    PC_BRANCH,
    PC_CALL,
    PC_RET,
    PC_TRAP
  } pc_sel_e;

  // Number of low address bits that must be zero for an aligned instruction.
  function automatic int unsigned align_width(input int unsigned instr_bytes);
    return $clog2(instr_bytes);
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry and the occupancy saturates; clear wins over push/pop.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned CNT_W    = $clog2(RAS_DEPTH + 1),
  localparam int unsigned PTR_W    = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [XLEN-1:0]  push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [XLEN-1:0]  top,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [XLEN-1:0]  entries [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] top_idx, next_idx;

  // Pointer/occupancy update; wr_ptr names the slot the next push writes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    top_idx  = (wr_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr_q - PTR_W'(1);
    next_idx = (wr_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push) begin
      wr_ptr_d = next_idx;
      if (count_q != CNT_W'(RAS_DEPTH)) count_d = count_q + CNT_W'(1);
    end else if (pop && (count_q != '0)) begin
      wr_ptr_d = top_idx;
      count_d  = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset discards the stack contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) entries[wr_ptr_q] <= push_data;
  end

  assign top   = entries[top_idx];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: priority next-PC mux (trap > stall > ret >
// branch/call > sequential) with a return-address stack and fault pulses.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned XLEN               = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR   = '0,
  parameter int unsigned INSTR_BYTES        = 4,
  parameter int unsigned RAS_DEPTH          = 4,
  localparam int unsigned CNT_W             = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  jump_address,
  input  logic             call,
  input  logic             ret,
  input  logic             trap_taken,
  input  logic [XLEN-1:0]  trap_vector,
  output logic [XLEN-1:0]  pc_out,
  output logic             pc_valid,
  output logic             misalign_fault,
  output logic             ras_underflow,
  output logic [CNT_W-1:0] ras_count
);

  localparam int unsigned ALIGN_W      = align_width(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_W) - 64'd1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q;
  logic            misalign_q, misalign_d;
  logic            underflow_q, underflow_d;

  pc_sel_e         sel;
  logic [XLEN-1:0] seq_pc;
  logic            jump_misaligned;
  logic            ras_push, ras_pop, ras_clear, ras_empty;
  logic [XLEN-1:0] ras_top;

  assign seq_pc          = pc_q + XLEN'(INSTR_BYTES);
  assign jump_misaligned = |(jump_address & ALIGN_MASK);

  // Next-PC source selection by priority; the first valid edge only holds.
  always_comb begin
    sel         = PC_SEQ;
    misalign_d  = 1'b0;
    underflow_d = 1'b0;
    if (!pc_valid_q) begin
      sel = PC_HOLD;
    end else if (trap_taken) begin
      sel = PC_TRAP;
    end else if (stall) begin
      sel = PC_HOLD;
    end else if (ret) begin
      if (!ras_empty) begin
        sel = PC_RET;
      end else begin
        // Empty stack falls back to the supplied target, like a plain branch.
        underflow_d = 1'b1;
        if (jump_misaligned) misalign_d = 1'b1;
        else                 sel = PC_BRANCH;
      end
    end else if (branch_taken) begin
      if (jump_misaligned) misalign_d = 1'b1;
      else                 sel = call ? PC_CALL : PC_BRANCH;
    end
  end

  // Next-PC data mux and stack control derived from the chosen source.
  always_comb begin
    pc_d      = pc_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    case (sel)
      PC_HOLD:   pc_d = pc_q;
      PC_SEQ:    pc_d = seq_pc;
      PC_BRANCH: pc_d = jump_address;
      PC_CALL: begin
        pc_d     = jump_address;
        ras_push = 1'b1;
      end
      PC_RET: begin
        pc_d    = ras_top;
        ras_pop = 1'b1;
      end
      PC_TRAP: begin
        pc_d      = trap_vector & ~ALIGN_MASK;
        ras_clear = 1'b1;
      end
      default:   pc_d = pc_q;
    endcase
  end

  // PC, valid flag and one-cycle fault pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_VECTOR;
      pc_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc_valid_q  <= 1'b1;
      misalign_q  <= misalign_d;
      underflow_q <= underflow_d;
    end
  end

  return_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .push_data (seq_pc),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .top       (ras_top),
    .empty     (ras_empty),
    .count     (ras_count)
  );

  assign pc_out         = pc_q;
  assign pc_valid       = pc_valid_q;
  assign misalign_fault = misalign_q;
  assign ras_underflow  = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] jump_address;
  logic        call;
  logic        ret;
  logic        trap_taken;
  logic [31:0] trap_vector;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        misalign_fault;
  logic        ras_underflow;
  logic [2:0]  ras_count;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .jump_address   (jump_address),
    .call           (call),
    .ret            (ret),
    .trap_taken     (trap_taken),
    .trap_vector    (trap_vector),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .misalign_fault (misalign_fault),
    .ras_underflow  (ras_underflow),
    .ras_count      (ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Set all inputs (applied at a falling edge).
  task automatic drive(input logic st, input logic br, input logic cl, input logic rt,
                       input logic tr, input logic [31:0] ja, input logic [31:0] tv);
    stall = st; branch_taken = br; call = cl; ret = rt;
    trap_taken = tr; jump_address = ja; trap_vector = tv;
  endtask

  // One rising edge, then settle to the next falling edge for sampling.
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step(); step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_cnt", {29'b0, ras_count}, 32'h0);
    chk("rst_mis", {31'b0, misalign_fault}, 32'h0);
    chk("rst_unf", {31'b0, ras_underflow}, 32'h0);

    // Reset release: 0, 4, 8
    rst_n = 1'b1;
    step();
    $display("release: pc=0x%0h valid=%0b", pc_out, pc_valid);
    chk("first_pc", pc_out, 32'h0);
    chk("first_valid", {31'b0, pc_valid}, 32'h1);
    step(); chk("seq_4", pc_out, 32'h4);
    step(); chk("seq_8", pc_out, 32'h8);

    // Branch then stall
    drive(0, 1, 0, 0, 0, 32'hA0, 0); step();
    $display("branch: pc=0x%0h", pc_out);
    chk("br_A0", pc_out, 32'hA0);
    idle(); step(); chk("seq_A4", pc_out, 32'hA4);
    drive(1, 0, 0, 0, 0, 0, 0); step(); chk("stall1", pc_out, 32'hA4);
    step(); chk("stall2", pc_out, 32'hA4);
    idle(); step(); chk("unstall", pc_out, 32'hA8);

    // Two calls, two returns
    drive(0, 1, 0, 0, 0, 32'h10, 0); step(); chk("br_10", pc_out, 32'h10);
    drive(0, 1, 1, 0, 0, 32'h100, 0); step();
    chk("call1_pc", pc_out, 32'h100); chk("call1_cnt", {29'b0, ras_count}, 32'd1);
    idle(); step(); chk("seq_104", pc_out, 32'h104);
    drive(0, 1, 1, 0, 0, 32'h200, 0); step();
    $display("call2: pc=0x%0h cnt=%0d", pc_out, ras_count);
    chk("call2_pc", pc_out, 32'h200); chk("call2_cnt", {29'b0, ras_count}, 32'd2);
    drive(0, 0, 0, 1, 0, 0, 0); step();
    chk("ret1_pc", pc_out, 32'h108); chk("ret1_cnt", {29'b0, ras_count}, 32'd1);
    step();
    chk("ret2_pc", pc_out, 32'h14); chk("ret2_cnt", {29'b0, ras_count}, 32'd0);

    // Five calls overflow the 4-deep stack; oldest (0x18) is lost
    drive(0, 1, 1, 0, 0, 32'h300, 0); step(); chk("c5a", pc_out, 32'h300);
    drive(0, 1, 1, 0, 0, 32'h400, 0); step(); chk("c5b", pc_out, 32'h400);
    drive(0, 1, 1, 0, 0, 32'h500, 0); step(); chk("c5c", pc_out, 32'h500);
    drive(0, 1, 1, 0, 0, 32'h600, 0); step();
    chk("c5d_cnt", {29'b0, ras_count}, 32'd4);
    drive(0, 1, 1, 0, 0, 32'h700, 0); step();
    chk("c5e_pc", pc_out, 32'h700); chk("c5e_cnt_sat", {29'b0, ras_count}, 32'd4);
    // ret takes priority over a simultaneous call
    drive(0, 1, 1, 1, 0, 32'h999, 0); step();
    chk("r5a_pc", pc_out, 32'h604); chk("r5a_cnt", {29'b0, ras_count}, 32'd3);
    drive(0, 0, 0, 1, 0, 0, 0); step(); chk("r5b_pc", pc_out, 32'h504);
    step(); chk("r5c_pc", pc_out, 32'h404);
    step(); chk("r5d_pc", pc_out, 32'h304); chk("r5d_cnt", {29'b0, ras_count}, 32'd0);
    chk("r5d_unf", {31'b0, ras_underflow}, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h900, 0); step();
    $display("underflow ret: pc=0x%0h unf=%0b", pc_out, ras_underflow);
    chk("r5e_pc", pc_out, 32'h900); chk("r5e_unf", {31'b0, ras_underflow}, 32'h1);
    // call without branch has no effect
    drive(0, 0, 1, 0, 0, 32'h123, 0); step();
    chk("unf_clear", {31'b0, ras_underflow}, 32'h0);
    chk("lone_call_pc", pc_out, 32'h904); chk("lone_call_cnt", {29'b0, ras_count}, 32'd0);

    // Misaligned branch
    drive(0, 1, 0, 0, 0, 32'h40, 0); step(); chk("br_40", pc_out, 32'h40);
    drive(0, 1, 0, 0, 0, 32'hA2, 0); step();
    $display("misalign: pc=0x%0h mis=%0b", pc_out, misalign_fault);
    chk("mis_pc", pc_out, 32'h44); chk("mis_pulse", {31'b0, misalign_fault}, 32'h1);
    idle(); step();
    chk("mis_pc2", pc_out, 32'h48); chk("mis_clear", {31'b0, misalign_fault}, 32'h0);

    // Trap during stall clears a 3-deep stack
    drive(0, 1, 1, 0, 0, 32'h1000, 0); step();
    drive(0, 1, 1, 0, 0, 32'h2000, 0); step();
    drive(0, 1, 1, 0, 0, 32'h3000, 0); step();
    chk("pre_trap_cnt", {29'b0, ras_count}, 32'd3);
    drive(1, 0, 0, 0, 1, 0, 32'h803); step();
    $display("trap: pc=0x%0h cnt=%0d", pc_out, ras_count);
    chk("trap_pc", pc_out, 32'h800); chk("trap_cnt", {29'b0, ras_count}, 32'd0);
    idle(); step(); chk("post_trap", pc_out, 32'h804);

    // Wrap around top of the address space
    drive(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0); step(); chk("br_top", pc_out, 32'hFFFF_FFFC);
    idle(); step(); chk("wrap_0", pc_out, 32'h0);

    // Asynchronous reset mid-operation
    drive(0, 1, 1, 0, 0, 32'h50, 0); step(); chk("pre_rst_cnt", {29'b0, ras_count}, 32'd1);
    drive(0, 1, 0, 0, 0, 32'h53, 0); step();
    chk("pre_rst_mis", {31'b0, misalign_fault}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_valid", {31'b0, pc_valid}, 32'h0);
    chk("arst_cnt", {29'b0, ras_count}, 32'd0);
    chk("arst_mis", {31'b0, misalign_fault}, 32'h0);
    // Redirect on the first edge after release is ignored
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 0, 32'h80, 0); step();
    chk("rel2_pc", pc_out, 32'h0); chk("rel2_valid", {31'b0, pc_valid}, 32'h1);
    step(); chk("rel2_br", pc_out, 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
